// File: rtl/mip_dispatch_fifo_gen.sv
`default_nettype none
// ============================================================================
// Module      : mip_dispatch_fifo_gen
// Description : Parametrised dispatch FIFO with standard or FWFT read mode,
//               programmable fill flags, error pulses and a post-reset busy
//               window.
// Revision    : 1.0 - initial release
// ============================================================================
module mip_dispatch_fifo_gen #(
    parameter int DATA_WIDTH        = 128,
    parameter int FIFO_DEPTH        = 1024,
    parameter int FWFT              = 0,
    parameter int PROG_FULL_THRESH  = FIFO_DEPTH - 16,
    parameter int PROG_EMPTY_THRESH = 16
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic                        wr_en,
    input  logic [DATA_WIDTH-1:0]       din,
    input  logic                        rd_en,
    output logic [DATA_WIDTH-1:0]       dout,
    output logic                        valid,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic                        prog_full,
    output logic                        prog_empty,
    output logic                        overflow,
    output logic                        underflow,
    output logic [$clog2(FIFO_DEPTH):0] data_count,
    output logic                        rst_busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] c_depth   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] c_afull   = CW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] c_pfull   = CW'(PROG_FULL_THRESH);
    localparam logic [CW-1:0] c_pempty  = CW'(PROG_EMPTY_THRESH);
    localparam logic [CW-1:0] c_cnt_one = CW'(1);
    localparam logic [AW-1:0] c_ptr_one = AW'(1);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_valid;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  r_rst_busy;
    logic                  r_busy_cnt;

    logic w_full;
    logic w_empty;
    logic w_rd_ok;
    logic w_wr_acc;
    logic w_rd_acc;

    assign w_full   = (r_count == c_depth);
    assign w_wr_acc = wr_en & ~w_full & ~r_rst_busy;
    assign w_rd_acc = rd_en & w_rd_ok & ~r_rst_busy;

    // Busy window covers the reset itself plus two edges after release.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_rst_busy <= 1'b1;
            r_busy_cnt <= 1'b0;
        end else if (r_rst_busy) begin
            r_busy_cnt <= 1'b1;
            if (r_busy_cnt) begin
                r_rst_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= wr_en & w_full & ~r_rst_busy;
            r_underflow <= rd_en & ~w_rd_ok & ~r_rst_busy;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_wr_acc & ~w_rd_acc) begin
                r_count <= r_count + c_cnt_one;
            end else if (~w_wr_acc & w_rd_acc) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // r_count includes the output register, so memory holds count - valid.
            logic [CW-1:0] w_mem_cnt;
            logic          w_load;

            assign w_mem_cnt = r_count - {{(CW-1){1'b0}}, r_valid};
            assign w_load    = (~r_valid | w_rd_acc) & (w_mem_cnt != '0);
            assign w_rd_ok   = r_valid;
            assign w_empty   = ~r_valid;

            always_ff @(posedge clk or posedge srst) begin
                if (srst) begin
                    r_rd_ptr <= '0;
                    r_dout   <= '0;
                    r_valid  <= 1'b0;
                end else if (w_load) begin
                    r_dout   <= r_mem[r_rd_ptr];
                    r_rd_ptr <= r_rd_ptr + c_ptr_one;
                    r_valid  <= 1'b1;
                end else if (w_rd_acc) begin
                    r_valid  <= 1'b0;
                end
            end
        end else begin : g_std
            assign w_rd_ok = (r_count != '0);
            assign w_empty = ~w_rd_ok;

            always_ff @(posedge clk or posedge srst) begin
                if (srst) begin
                    r_rd_ptr <= '0;
                    r_dout   <= '0;
                    r_valid  <= 1'b0;
                end else begin
                    r_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_dout   <= r_mem[r_rd_ptr];
                        r_rd_ptr <= r_rd_ptr + c_ptr_one;
                    end
                end
            end
        end
    endgenerate

    assign dout         = r_dout;
    assign valid        = r_valid;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_afull);
    assign almost_empty = (r_count <= c_cnt_one);
    assign prog_full    = (r_count >= c_pfull);
    assign prog_empty   = (r_count <= c_pempty);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign data_count   = r_count;
    assign rst_busy     = r_rst_busy;

endmodule
`default_nettype wire
